// File: rtl/pkg_tpu.sv
// Shared scalar-unit types: register data/index types and the hard-wired zero register.
package pkg_tpu;
  localparam int NUM_SREG   = 64;
  localparam int WIDTH_SREG = 32;

  typedef logic [WIDTH_SREG-1:0]       data_t;
  typedef logic [$clog2(NUM_SREG)-1:0] index_t;

  localparam index_t SREG_ZERO = '0;
endpackage

// File: rtl/scoreboard_s.sv
// Pending-write scoreboard: one bit per scalar register, set on reservation, cleared on write-back.
module scoreboard_s
  import pkg_tpu::*;
#(
  parameter int NUM_ENTRY = NUM_SREG
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_en,
  input  index_t     set_idx,
  input  logic       clr_en,
  input  index_t     clr_idx,
  input  index_t     look_idx [4],
  output logic [3:0] look_pend
);

  logic [NUM_ENTRY-1:0] pend;

  // The set is applied after the clear so a same-cycle collision leaves the entry pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend <= '0;
    end else begin
      if (clr_en && clr_idx != SREG_ZERO) pend[clr_idx] <= 1'b0;
      if (set_en && set_idx != SREG_ZERO) pend[set_idx] <= 1'b1;
    end
  end

  always_comb begin
    look_pend = '0;
    for (int i = 0; i < 4; i++) look_pend[i] = pend[look_idx[i]];
  end

endmodule

// File: rtl/regfile_read_s.sv
// Scalar register-read stage: four read ports with write-through, RAW hazard detect and a
// one-deep output register feeding the scalar operand network.
module regfile_read_s
  import pkg_tpu::*;
#(
  parameter int NUM_ENTRY  = NUM_SREG,
  parameter int WIDTH_DATA = $bits(data_t)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       I_Stall,
  input  logic       I_Req,
  input  logic [3:0] I_Re,
  input  index_t     I_Idx1,
  input  index_t     I_Idx2,
  input  index_t     I_Idx3,
  input  index_t     I_Idx4,
  input  logic       I_Dst_Valid,
  input  index_t     I_Dst_Idx,
  input  logic       I_WB_We,
  input  index_t     I_WB_DstIdx,
  input  data_t      I_WB_Data,
  output logic       O_Req,
  output data_t      O_Src_Data1,
  output data_t      O_Src_Data2,
  output data_t      O_Src_Data3,
  output data_t      O_Src_Data4,
  output index_t     O_Src_Idx1,
  output index_t     O_Src_Idx2,
  output index_t     O_Src_Idx3,
  output index_t     O_Src_Idx4,
  output logic       O_Hazard
);

  logic [WIDTH_DATA-1:0] rf [NUM_ENTRY];

  index_t     rd_idx [4];
  data_t      rd_val [4];
  logic [3:0] pend_hit;
  logic [3:0] blocked;
  logic       accept;
  logic       wb_valid;

  logic       req_q;
  data_t      src_data [4];
  index_t     src_idx  [4];

  assign rd_idx[0] = I_Idx1;
  assign rd_idx[1] = I_Idx2;
  assign rd_idx[2] = I_Idx3;
  assign rd_idx[3] = I_Idx4;

  assign wb_valid = I_WB_We && (I_WB_DstIdx != SREG_ZERO);

  scoreboard_s #(.NUM_ENTRY(NUM_ENTRY)) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .set_en    (accept && I_Dst_Valid),
    .set_idx   (I_Dst_Idx),
    .clr_en    (I_WB_We),
    .clr_idx   (I_WB_DstIdx),
    .look_idx  (rd_idx),
    .look_pend (pend_hit)
  );

  always_comb begin
    blocked = '0;
    for (int i = 0; i < 4; i++) begin
      blocked[i] = I_Re[i] && pend_hit[i] && !(I_WB_We && I_WB_DstIdx == rd_idx[i]);
      if (wb_valid && I_WB_DstIdx == rd_idx[i])
        rd_val[i] = I_WB_Data;
      else if (rd_idx[i] == SREG_ZERO)
        rd_val[i] = '0;
      else
        rd_val[i] = rf[rd_idx[i]];
    end
  end

  assign O_Hazard = I_Req && (|blocked);
  assign accept   = I_Req && !I_Stall && !O_Hazard;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_ENTRY; k++) rf[k] <= '0;
    end else if (wb_valid) begin
      rf[I_WB_DstIdx] <= I_WB_Data;
    end
  end

  // While stalled, held data tracks write-back so nothing stale leaves on release.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        src_data[i] <= '0;
        src_idx[i]  <= '0;
      end
    end else if (!I_Stall) begin
      req_q <= accept;
      if (accept) begin
        for (int i = 0; i < 4; i++) begin
          src_idx[i]  <= rd_idx[i];
          src_data[i] <= I_Re[i] ? rd_val[i] : '0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wb_valid && I_WB_DstIdx == src_idx[i]) src_data[i] <= I_WB_Data;
      end
    end
  end

  assign O_Req       = req_q;
  assign O_Src_Data1 = src_data[0];
  assign O_Src_Data2 = src_data[1];
  assign O_Src_Data3 = src_data[2];
  assign O_Src_Data4 = src_data[3];
  assign O_Src_Idx1  = src_idx[0];
  assign O_Src_Idx2  = src_idx[1];
  assign O_Src_Idx3  = src_idx[2];
  assign O_Src_Idx4  = src_idx[3];

endmodule

// File: tb/tb_regfile_read_s.sv
// Bench for regfile_read_s: directed scenarios with literal expectations, then random traffic
// compared every cycle against an array/bit-vector model of the register-read stage.
module tb_regfile_read_s;
  import pkg_tpu::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       I_Stall, I_Req, I_Dst_Valid, I_WB_We;
  logic [3:0] I_Re;
  index_t     I_Idx1, I_Idx2, I_Idx3, I_Idx4, I_Dst_Idx, I_WB_DstIdx;
  data_t      I_WB_Data;
  logic       O_Req, O_Hazard;
  data_t      O_Src_Data1, O_Src_Data2, O_Src_Data3, O_Src_Data4;
  index_t     O_Src_Idx1, O_Src_Idx2, O_Src_Idx3, O_Src_Idx4;

  always #5 clock = ~clock;

  regfile_read_s dut (
    .clock(clock), .reset(reset), .I_Stall(I_Stall), .I_Req(I_Req), .I_Re(I_Re),
    .I_Idx1(I_Idx1), .I_Idx2(I_Idx2), .I_Idx3(I_Idx3), .I_Idx4(I_Idx4),
    .I_Dst_Valid(I_Dst_Valid), .I_Dst_Idx(I_Dst_Idx),
    .I_WB_We(I_WB_We), .I_WB_DstIdx(I_WB_DstIdx), .I_WB_Data(I_WB_Data),
    .O_Req(O_Req),
    .O_Src_Data1(O_Src_Data1), .O_Src_Data2(O_Src_Data2),
    .O_Src_Data3(O_Src_Data3), .O_Src_Data4(O_Src_Data4),
    .O_Src_Idx1(O_Src_Idx1), .O_Src_Idx2(O_Src_Idx2),
    .O_Src_Idx3(O_Src_Idx3), .O_Src_Idx4(O_Src_Idx4),
    .O_Hazard(O_Hazard)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  data_t  m_rf   [64];
  bit     m_pend [64];
  bit     m_req;
  index_t m_idx  [4];
  data_t  m_data [4];

  function automatic index_t in_idx(input int p);
    case (p)
      0: return I_Idx1;
      1: return I_Idx2;
      2: return I_Idx3;
      default: return I_Idx4;
    endcase
  endfunction

  function automatic bit m_hazard();
    bit h = 1'b0;
    for (int p = 0; p < 4; p++) begin
      index_t ix = in_idx(p);
      if (I_Re[p] && m_pend[ix] && !(I_WB_We && I_WB_DstIdx == ix)) h = 1'b1;
    end
    return I_Req && h;
  endfunction

  function automatic data_t m_read(input index_t ix);
    if (ix == 0) return '0;
    if (I_WB_We && I_WB_DstIdx == ix) return I_WB_Data;
    return m_rf[ix];
  endfunction

  always @(posedge clock) begin : model_blk
    bit    hz, acc;
    data_t rd [4];
    if (reset) begin
      for (int k = 0; k < 64; k++) begin m_rf[k] = '0; m_pend[k] = 1'b0; end
      m_req = 1'b0;
      for (int p = 0; p < 4; p++) begin m_idx[p] = '0; m_data[p] = '0; end
    end else begin
      hz  = m_hazard();
      acc = I_Req && !I_Stall && !hz;
      for (int p = 0; p < 4; p++) rd[p] = m_read(in_idx(p));
      if (!I_Stall) begin
        m_req = acc;
        if (acc)
          for (int p = 0; p < 4; p++) begin
            m_idx[p]  = in_idx(p);
            m_data[p] = I_Re[p] ? rd[p] : '0;
          end
      end else begin
        for (int p = 0; p < 4; p++)
          if (I_WB_We && I_WB_DstIdx != 0 && I_WB_DstIdx == m_idx[p]) m_data[p] = I_WB_Data;
      end
      if (I_WB_We && I_WB_DstIdx != 0) m_rf[I_WB_DstIdx] = I_WB_Data;
      if (I_WB_We) m_pend[I_WB_DstIdx] = 1'b0;
      if (acc && I_Dst_Valid && I_Dst_Idx != 0) m_pend[I_Dst_Idx] = 1'b1;
    end
  end

  data_t  o_data [4];
  index_t o_idx  [4];
  assign o_data[0] = O_Src_Data1;  assign o_idx[0] = O_Src_Idx1;
  assign o_data[1] = O_Src_Data2;  assign o_idx[1] = O_Src_Idx2;
  assign o_data[2] = O_Src_Data3;  assign o_idx[2] = O_Src_Idx3;
  assign o_data[3] = O_Src_Data4;  assign o_idx[3] = O_Src_Idx4;

  always @(negedge clock) begin
    if (chk_on && !reset) begin
      chk("model_hazard", O_Hazard, m_hazard());
      chk("model_req", O_Req, m_req);
      if (m_req)
        for (int p = 0; p < 4; p++) begin
          chk($sformatf("model_idx%0d", p + 1), o_idx[p], m_idx[p]);
          chk($sformatf("model_data%0d", p + 1), o_data[p], m_data[p]);
        end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    I_Stall = 0; I_Req = 0; I_Re = '0;
    I_Idx1 = '0; I_Idx2 = '0; I_Idx3 = '0; I_Idx4 = '0;
    I_Dst_Valid = 0; I_Dst_Idx = '0;
    I_WB_We = 0; I_WB_DstIdx = '0; I_WB_Data = '0;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk_on = 1;

    // write then read
    I_WB_We = 1; I_WB_DstIdx = 6'd3; I_WB_Data = 32'hDEADBEEF;
    tick();
    idle(); I_Req = 1; I_Re = 4'b0001; I_Idx1 = 6'd3;
    tick();
    chk("t2_req", O_Req, 1);
    chk("t2_data1", O_Src_Data1, 32'hDEADBEEF);
    chk("t2_idx1", O_Src_Idx1, 3);

    // write-through on two ports; r0 stays zero
    idle(); I_WB_We = 1; I_WB_DstIdx = 6'd7; I_WB_Data = 32'h11;
    I_Req = 1; I_Re = 4'b1001; I_Idx1 = 6'd7; I_Idx4 = 6'd7; I_Idx2 = 6'd3;
    tick();
    chk("t3_data1", O_Src_Data1, 32'h11);
    chk("t3_data4", O_Src_Data4, 32'h11);
    chk("t3_data2_disabled", O_Src_Data2, 0);
    idle(); I_WB_We = 1; I_WB_DstIdx = 6'd0; I_WB_Data = 32'hFFFF_FFFF;
    I_Req = 1; I_Re = 4'b0001; I_Idx1 = 6'd0;
    tick();
    chk("t3_r0_same", O_Src_Data1, 0);
    idle(); I_Req = 1; I_Re = 4'b0001; I_Idx1 = 6'd0;
    tick();
    chk("t3_r0_after", O_Src_Data1, 0);

    // hazard on reserved r9, released by same-cycle write-back
    idle(); I_Req = 1; I_Dst_Valid = 1; I_Dst_Idx = 6'd9;
    tick();
    idle(); I_Req = 1; I_Re = 4'b0001; I_Idx1 = 6'd9;
    #1 chk("t4_hazard", O_Hazard, 1);
    tick();
    chk("t4_bubble", O_Req, 0);
    I_WB_We = 1; I_WB_DstIdx = 6'd9; I_WB_Data = 32'h55;
    #1 chk("t4_hazard_clr", O_Hazard, 0);
    tick();
    chk("t4_req", O_Req, 1);
    chk("t4_data1", O_Src_Data1, 32'h55);

    // stall with write-back refresh of held data
    idle(); I_Req = 1; I_Re = 4'b0010; I_Idx2 = 6'd4;
    tick();
    chk("t5_data2_pre", O_Src_Data2, 0);
    I_Stall = 1;
    for (int s = 0; s < 3; s++) begin
      I_WB_We = (s == 1); I_WB_DstIdx = 6'd4; I_WB_Data = 32'hA5A5;
      tick();
      chk("t5_req_held", O_Req, 1);
      chk("t5_idx2_held", O_Src_Idx2, 4);
      chk("t5_data2", O_Src_Data2, (s >= 1) ? 32'hA5A5 : 32'h0);
    end
    I_Stall = 0; I_WB_We = 0;
    tick();
    chk("t5_release_req", O_Req, 1);
    chk("t5_release_data2", O_Src_Data2, 32'hA5A5);

    // set/clear collision on r12: set wins
    idle(); I_Req = 1; I_Dst_Valid = 1; I_Dst_Idx = 6'd12;
    I_WB_We = 1; I_WB_DstIdx = 6'd12; I_WB_Data = 32'h77;
    tick();
    idle(); I_Req = 1; I_Re = 4'b0001; I_Idx1 = 6'd12;
    #1 chk("t6_hazard", O_Hazard, 1);
    tick();
    chk("t6_bubble", O_Req, 0);

    // reset mid-stream clears RF, outputs and reservations
    idle(); I_WB_We = 1; I_WB_DstIdx = 6'd5; I_WB_Data = 32'h1234;
    tick();
    idle(); I_Req = 1; I_Re = 4'b0001; I_Idx1 = 6'd5;
    tick();
    chk("t1_pre_data1", O_Src_Data1, 32'h1234);
    reset = 1;
    tick(); tick();
    chk("t1_req", O_Req, 0);
    chk("t1_data1", O_Src_Data1, 0);
    chk("t1_idx1", O_Src_Idx1, 0);
    chk("t1_data4", O_Src_Data4, 0);
    reset = 0;
    idle(); I_Req = 1; I_Re = 4'b0011; I_Idx1 = 6'd12; I_Idx2 = 6'd5;
    #1 chk("t1_no_pend", O_Hazard, 0);
    tick();
    chk("t1_post_req", O_Req, 1);
    chk("t1_r12", O_Src_Data1, 0);
    chk("t1_r5", O_Src_Data2, 0);

    // random traffic on a narrow index range to provoke hazards and forwarding
    for (int c = 0; c < 1500; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      I_Stall     = ($urandom_range(0, 4) == 0);
      I_Req       = ($urandom_range(0, 9) < 7);
      I_Re        = 4'($urandom());
      I_Idx1      = index_t'($urandom_range(0, 15));
      I_Idx2      = index_t'($urandom_range(0, 15));
      I_Idx3      = index_t'($urandom_range(0, 15));
      I_Idx4      = index_t'($urandom_range(0, 15));
      I_Dst_Valid = ($urandom_range(0, 1) == 1);
      I_Dst_Idx   = index_t'($urandom_range(0, 15));
      I_WB_We     = ($urandom_range(0, 9) < 4);
      I_WB_DstIdx = index_t'($urandom_range(0, 15));
      I_WB_Data   = $urandom();
      tick();
    end
    reset = 0;
    idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
